// File: rtl/ssram_pkg.sv
// Shared constants and types for the single-port word SRAM and its response path.
package ssram_pkg;

    localparam int unsigned SSRAM_DEPTH_DEF = 16384;
    localparam int unsigned RSP_DEPTH       = 2;
    localparam int unsigned WORD_W          = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/ssram_rsp_fifo.sv
// Small in-order response buffer: push/pop of 32-bit words, head always visible.
// Zero-latency head read; push is ignored when full, pop is ignored when empty.
module ssram_rsp_fifo
    import ssram_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  word_t                        push_dat_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output word_t                        head_dat_o,
    output logic [$clog2(RSP_DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(RSP_DEPTH);

    word_t         buf_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o     = (cnt_q == (PW+1)'(RSP_DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign head_dat_o = buf_q[rd_ptr_q];
    assign count_o    = cnt_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            buf_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/ssram.sv
// Word-addressed synchronous SRAM with valid/ready request and response channels.
// Read latency 1 cycle when idle; up to 2 responses held, treqready_o drops when full.
module ssram
    import ssram_pkg::*;
#(
    parameter int unsigned C_DEPTH = SSRAM_DEPTH_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic [31:0] trspdata_o
);

    localparam int unsigned AW = $clog2(C_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

    word_t          mem [C_DEPTH];
    logic [AW-1:0]  widx;
    logic           unused_addr;

    logic           run;
    logic           acc, acc_rd, acc_wr;
    logic           consume, push, pop;
    logic           rdy_q, rdy_d;
    logic           s_vld_q, s_vld_d;
    word_t          s_dat_q;
    logic [CW:0]    cnt_nxt, occ_d;

    logic           f_full, f_empty;
    word_t          f_head;
    logic [CW-1:0]  f_cnt;

    assign widx        = treqaddr_i[AW+1:2];
    assign unused_addr = ^{treqaddr_i[31:AW+2], treqaddr_i[1:0]};

    assign run         = clk_en_i & ~reset_i;
    assign treqready_o = rdy_q & run;
    assign acc         = treqvalid_i & treqready_o;
    assign acc_rd      = acc & ~treqdvalid_i;
    assign acc_wr      = acc & treqdvalid_i;

    // The stage register is shown directly while the buffer is empty, so an
    // idle read answers one cycle after acceptance without a buffer hop.
    assign trspvalid_o = (s_vld_q | ~f_empty) & run;
    assign trspdata_o  = reset_i ? '0 : (f_empty ? s_dat_q : f_head);
    assign consume     = trspvalid_o & trspready_i;
    assign pop         = consume & ~f_empty;
    assign push        = run & s_vld_q & ~f_full & ~(consume & f_empty);

    always_comb begin
        s_vld_d = s_vld_q;
        if (run) begin
            s_vld_d = acc_rd;
        end
        cnt_nxt = (CW+1)'(f_cnt) + (CW+1)'(push) - (CW+1)'(pop);
        occ_d   = cnt_nxt + (CW+1)'(s_vld_d);
        rdy_d   = (occ_d < (CW+1)'(RSP_DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdy_q   <= 1'b1;
            s_vld_q <= 1'b0;
        end else if (clk_en_i) begin
            rdy_q   <= rdy_d;
            s_vld_q <= s_vld_d;
        end
    end

    // Array and read register kept reset-free so they map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            mem[widx] <= treqdata_i;
        end
        if (acc_rd) begin
            s_dat_q <= mem[widx];
        end
    end

    ssram_rsp_fifo u_rsp_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (push),
        .push_dat_i (s_dat_q),
        .pop_i      (pop),
        .full_o     (f_full),
        .empty_o    (f_empty),
        .head_dat_o (f_head),
        .count_o    (f_cnt)
    );

endmodule

// File: tb/tb_ssram.sv
// Directed vector bench for ssram at depth 16, plus a streaming read sequence.
module tb_ssram;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        treqready;
    logic        treqvalid;
    logic        treqdvalid;
    logic [31:0] treqaddr;
    logic [31:0] treqdata;
    logic        trspready;
    logic        trspvalid;
    logic [31:0] trspdata;

    int tests = 0;
    int fails = 0;

    ssram #(.C_DEPTH(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .clk_en_i     (clk_en),
        .treqready_o  (treqready),
        .treqvalid_i  (treqvalid),
        .treqdvalid_i (treqdvalid),
        .treqaddr_i   (treqaddr),
        .treqdata_i   (treqdata),
        .trspready_i  (trspready),
        .trspvalid_o  (trspvalid),
        .trspdata_o   (trspdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, vld, wr;
        logic [31:0] addr, dat;
        logic        rdy;
        logic        e_rdy, e_vld, e_chk;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic vld,
                                input logic wr, input logic [31:0] addr,
                                input logic [31:0] dat, input logic rdy,
                                input logic e_rdy, input logic e_vld,
                                input logic e_chk, input logic [31:0] e_dat);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.wr = wr;
        v.addr = addr; v.dat = dat; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_chk = e_chk; v.e_dat = e_dat;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic vld,
                         input logic wr, input logic [31:0] addr,
                         input logic [31:0] dat, input logic rdy);
        reset = rst; clk_en = en; treqvalid = vld; treqdvalid = wr;
        treqaddr = addr; treqdata = dat; trspready = rdy;
    endtask

    localparam logic [31:0] A1 = 32'hA1A1_A1A1;
    localparam logic [31:0] B2 = 32'hB2B2_B2B2;
    localparam logic [31:0] C3 = 32'hC3C3_C3C3;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] ON = 32'h1111_1111;
    localparam logic [31:0] AL = 32'h1234_5678;

    initial begin
        //                rst en vld wr addr      dat           rdy  rdy vld chk data
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 32'h0,        0,   0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h10, DB,           1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h10, 32'h0,        1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 1, 1, DB));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));
        // write then immediate read of the same word
        vecs.push_back(mk(0, 1, 1, 1, 32'h20, ON,           1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h20, 32'h0,        1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 1, 1, ON));
        // backpressure: three reads offered, only two fit
        vecs.push_back(mk(0, 1, 1, 1, 32'h30, A1,           0,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h34, B2,           0,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h38, C3,           0,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h30, 32'h0,        0,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h34, 32'h0,        0,   1, 1, 1, A1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h38, 32'h0,        0,   0, 1, 1, A1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        0,   0, 1, 1, A1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   0, 1, 1, A1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 1, 1, B2));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));
        // aliasing: 0x44 and 0x07 both hit word 1 at depth 16
        vecs.push_back(mk(0, 1, 1, 1, 32'h04, AL,           1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h44, 32'h0,        1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h07, 32'h0,        1,   1, 1, 1, AL));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 1, 1, AL));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));
        // clock enable low: write dropped, outputs forced low, state held
        vecs.push_back(mk(0, 1, 1, 0, 32'h30, 32'h0,        0,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h30, 32'hFFFFFFFF, 1,   0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h30, 32'h0,        0,   1, 1, 1, A1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   0, 1, 1, A1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 1, 1, A1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));
        // reset with two responses pending
        vecs.push_back(mk(0, 1, 1, 0, 32'h34, 32'h0,        0,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h38, 32'h0,        0,   1, 1, 1, B2));
        vecs.push_back(mk(1, 1, 0, 0, 32'h00, 32'h0,        1,   0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h10, 32'h0,        1,   1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 1, 1, DB));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 32'h0,        1,   1, 0, 0, 32'h0));

        drive(1, 1, 0, 0, 32'h0, 32'h0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].wr,
                  vecs[i].addr, vecs[i].dat, vecs[i].rdy);
            @(negedge clk);
            chk("treqready", i, {31'b0, treqready}, {31'b0, vecs[i].e_rdy});
            chk("trspvalid", i, {31'b0, trspvalid}, {31'b0, vecs[i].e_vld});
            if (vecs[i].e_chk) chk("trspdata", i, trspdata, vecs[i].e_dat);
            @(posedge clk); #1;
        end

        // eight back-to-back reads must stream one response per cycle
        for (int w = 0; w < 8; w++) begin
            drive(0, 1, 1, 1, 32'(w * 4), 32'h0100_0000 + 32'(w), 1);
            @(posedge clk); #1;
        end
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) drive(0, 1, 1, 0, 32'(c * 4), 32'h0, 1);
            else       drive(0, 1, 0, 0, 32'h0, 32'h0, 1);
            @(negedge clk);
            chk("stream_rdy", 100 + c, {31'b0, treqready}, 32'h1);
            chk("stream_vld", 100 + c, {31'b0, trspvalid}, (c > 0) ? 32'h1 : 32'h0);
            if (c > 0) chk("stream_dat", 100 + c, trspdata, 32'h0100_0000 + 32'(c - 1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stream_end_vld", 109, {31'b0, trspvalid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
